// File: rtl/div_issuer_pkg.sv
// div_issuer_pkg -- shared op/state encodings and divide-by-zero constant.
// Rev 1.0
`default_nettype none

package div_issuer_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/div_issuer_zero_fix.sv
// div_zero_fix -- local result for a zero divisor: all-ones quotient, remainder = dividend.
// Rev 1.0
`default_nettype none

module div_zero_fix
  import div_issuer_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  output logic [31:0] res
);

  always_comb begin
    res = a;
    if (op_e'(op) == OP_DIV || op_e'(op) == OP_DIVU) begin
      res = DIV_BY_ZERO_Q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/div_issuer.sv
// div_issuer -- single-outstanding request sequencer in front of an external divider.
// Rev 1.0
`default_nettype none

module div_issuer
  import div_issuer_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [31:0] io_in_a,
  input  logic [31:0] io_in_b,
  input  logic [1:0]  io_in_op,
  output logic        io_div_v,
  output logic [31:0] io_div_a,
  output logic [31:0] io_div_b,
  output logic [1:0]  io_div_op,
  input  logic [31:0] io_div_res,
  input  logic        io_div_res_valid,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_res,
  output logic [1:0]  io_out_op,
  output logic        io_out_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic [1:0]      op_q;
  logic [31:0]     dz_res;

  div_zero_fix u_zero_fix (
    .op  (io_in_op),
    .a   (io_in_a),
    .res (dz_res)
  );

  assign cnt_inc   = cnt + CW'(1);
  assign io_div_a  = a_q;
  assign io_div_b  = b_q;
  assign io_div_op = op_q;
  assign io_out_op = op_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      io_in_ready  <= 1'b1;
      io_div_v     <= 1'b0;
      io_out_valid <= 1'b0;
      io_out_res   <= '0;
      io_out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid && io_in_ready) begin
            a_q         <= io_in_a;
            b_q         <= io_in_b;
            op_q        <= io_in_op;
            io_in_ready <= 1'b0;
            if (io_in_b != '0) begin
              state    <= ISSUE;
              io_div_v <= 1'b1;
            end else begin
              state        <= RESP;
              io_out_valid <= 1'b1;
              io_out_res   <= dz_res;
              io_out_err   <= 1'b0;
            end
          end
        end
        ISSUE: begin
          io_div_v <= 1'b0;
          cnt      <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_inc;
          // A result arriving on the last permitted cycle still beats the abort.
          if (io_div_res_valid) begin
            io_out_res   <= io_div_res;
            io_out_err   <= 1'b0;
            io_out_valid <= 1'b1;
            state        <= RESP;
          end else if (cnt_inc == CW'(TIMEOUT)) begin
            io_out_res   <= '0;
            io_out_err   <= 1'b1;
            io_out_valid <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (io_out_ready) begin
            io_out_valid <= 1'b0;
            io_in_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_issuer.sv
// tb_div_issuer -- scoreboard bench with a reactive divider model and random traffic.
// Rev 1.0
`default_nettype none

module tb_div_issuer;
  import div_issuer_pkg::*;

  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_valid, io_in_ready;
  logic [31:0] io_in_a, io_in_b;
  logic [1:0]  io_in_op;
  logic        io_div_v;
  logic [31:0] io_div_a, io_div_b;
  logic [1:0]  io_div_op;
  logic [31:0] io_div_res;
  logic        io_div_res_valid;
  logic        io_out_valid, io_out_ready;
  logic [31:0] io_out_res;
  logic [1:0]  io_out_op;
  logic        io_out_err;

  always #5 clock = ~clock;

  div_issuer #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_a(io_in_a), .io_in_b(io_in_b), .io_in_op(io_in_op),
    .io_div_v(io_div_v), .io_div_a(io_div_a), .io_div_b(io_div_b), .io_div_op(io_div_op),
    .io_div_res(io_div_res), .io_div_res_valid(io_div_res_valid),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_res(io_out_res), .io_out_op(io_out_op), .io_out_err(io_out_err)
  );

  typedef struct {
    logic [31:0] res;
    logic [1:0]  op;
    logic        err;
    int          lat;
    int          pulses;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;

  // divider-model / handshake controls written by the driver
  int          dly = 0;
  int          pend = 0;
  int          pulses = 0;
  int          stall = 0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr = '0;
  logic [31:0] cur_a = '0, cur_b = '0;
  logic [1:0]  cur_op = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural RISC-V style division results.
  function automatic logic [31:0] golden(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    logic               ovf;
    sa  = a;
    sbv = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0:    return ovf ? a : 32'(sa / sbv);
      2'd1:    return a / b;
      2'd2:    return ovf ? 32'd0 : 32'(sa % sbv);
      default: return a % b;
    endcase
  endfunction

  // Divider model: answers dly cycles after the issue pulse (0 = never); injects stray
  // result strobes only while the issuer is idle or responding.
  initial begin
    io_div_res_valid = 1'b0;
    io_div_res       = '0;
    forever begin
      @(posedge clock); #1;
      io_div_res_valid = 1'b0;
      if (io_div_v) begin
        pulses++;
        check("div_a", io_div_a, cur_a);
        check("div_b", io_div_b, cur_b);
        check("div_op", 32'(io_div_op), 32'(cur_op));
        pend = dly;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          io_div_res_valid = 1'b1;
          io_div_res = ovr_en ? ovr : golden(io_div_op, io_div_a, io_div_b);
        end
      end else if ((io_out_valid || io_in_ready) && $urandom_range(0, 9) == 0) begin
        io_div_res_valid = 1'b1;
        io_div_res = $urandom;
      end
    end
  end

  initial begin
    io_out_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (io_out_valid && stall > 0) begin
        io_out_ready = 1'b0;
        stall--;
      end else begin
        io_out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each response handshake.
  initial begin
    logic        prev_v;
    logic [31:0] h_res;
    logic [1:0]  h_op;
    logic        h_err;
    int          rise;
    exp_t        e;
    prev_v = 1'b0; h_res = '0; h_op = '0; h_err = 1'b0; rise = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_v = 1'b0;
      end else begin
        if (sbq.size() > 0) check("busy_in_ready", 32'(io_in_ready), 32'd0);
        if (io_out_valid && !prev_v) begin
          rise = cyc; h_res = io_out_res; h_op = io_out_op; h_err = io_out_err;
        end else if (io_out_valid) begin
          check("hold_res", io_out_res, h_res);
          check("hold_op", 32'(io_out_op), 32'(h_op));
          check("hold_err", 32'(io_out_err), 32'(h_err));
        end
        if (io_out_valid && io_out_ready) begin
          if (sbq.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_resp: got res %h with no request outstanding", io_out_res);
          end else begin
            e = sbq.pop_front();
            check("res", io_out_res, e.res);
            check("op", 32'(io_out_op), 32'(e.op));
            check("err", 32'(io_out_err), 32'(e.err));
            check("latency", 32'(rise - e.acc + 1), 32'(e.lat));
            check("div_pulses", 32'(pulses), 32'(e.pulses));
          end
        end
        prev_v = io_out_valid;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int d, input logic oe, input logic [31:0] ov, input int st);
    exp_t e;
    int   n;
    logic answered;
    n = 0;
    while (!io_in_ready && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    if (!io_in_ready) begin
      vectors++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 500 cycles");
      return;
    end
    cur_a = a; cur_b = b; cur_op = op;
    dly = d; ovr_en = oe; ovr = ov; stall = st; pulses = 0;
    io_in_valid = 1'b1; io_in_a = a; io_in_b = b; io_in_op = op;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    answered = (d >= 1) && (d <= TIMEOUT);
    e.op     = op;
    e.acc    = cyc;
    e.pulses = (b != 0) ? 1 : 0;
    if (b == 0) begin
      e.res = (op == 2'd0 || op == 2'd1) ? 32'hFFFF_FFFF : a;
      e.err = 1'b0;
      e.lat = 1;
    end else if (answered) begin
      e.res = oe ? ov : golden(op, a, b);
      e.err = 1'b0;
      e.lat = d + 2;
    end else begin
      e.res = '0;
      e.err = 1'b1;
      e.lat = TIMEOUT + 2;
    end
    sbq.push_back(e);
  endtask

  initial begin
    int          d, r, n;
    logic [31:0] b;
    io_in_valid = 1'b0; io_in_a = '0; io_in_b = '0; io_in_op = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 32'(io_in_ready), 32'd1);
    check("rst_div_v", 32'(io_div_v), 32'd0);
    check("rst_out_valid", 32'(io_out_valid), 32'd0);
    check("rst_out_err", 32'(io_out_err), 32'd0);
    check("rst_out_res", io_out_res, 32'd0);
    check("rst_div_a", io_div_a, 32'd0);
    check("rst_div_b", io_div_b, 32'd0);
    check("rst_div_op", 32'(io_div_op), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    check("post_rst_in_ready", 32'(io_in_ready), 32'd1);

    send(OP_DIV,  32'd100,      32'd7,  5,           1'b0, '0,     0);
    send(OP_REMU, 32'h1234,     32'd0,  0,           1'b0, '0,     0);
    send(OP_DIV,  32'd5,        32'd3,  0,           1'b0, '0,     0);
    send(OP_DIVU, 32'hDEADBEEF, 32'd16, 3,           1'b0, '0,     10);
    send(OP_DIV,  32'd9,        32'd2,  TIMEOUT,     1'b1, 32'd42, 0);
    send(OP_REM,  32'd9,        32'd4,  TIMEOUT + 1, 1'b0, '0,     2);
    send(OP_DIV,  32'hFFFF_FFF9, 32'd0, 0,           1'b0, '0,     0);
    send(OP_DIVU, 32'd77,       32'd0,  0,           1'b0, '0,     1);
    send(OP_REM,  32'h8000_0000, 32'd0, 0,           1'b0, '0,     0);
    send(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1,   1'b0, '0,     0);

    // Reset in the third WAIT cycle; the divider answers later and must be ignored.
    send(OP_DIV, 32'd1000, 32'd3, 10, 1'b0, '0, 0);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    if (sbq.size() > 0) void'(sbq.pop_back());
    #1;
    check("midrst_out_valid", 32'(io_out_valid), 32'd0);
    check("midrst_in_ready", 32'(io_in_ready), 32'd1);
    check("midrst_div_a", io_div_a, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (20) begin
      @(posedge clock); #1;
      check("postrst_out_valid", 32'(io_out_valid), 32'd0);
      check("postrst_in_ready", 32'(io_in_ready), 32'd1);
    end

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      d = 0;
      else if (r == 1) d = TIMEOUT + 1;
      else if (r == 2) d = TIMEOUT;
      else             d = $urandom_range(1, 8);
      b = ($urandom_range(0, 3) == 0) ? 32'd0 :
          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
      send(2'($urandom_range(0, 3)), 32'($urandom), b, d, 1'b0, '0, $urandom_range(0, 3));
    end

    n = 0;
    while (sbq.size() > 0 && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    if (sbq.size() > 0) begin
      vectors++; errors++;
      $display("FAIL drain: got %0d responses outstanding expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
